// File: rtl/mul_arb_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: default sizes,
// FSM state encoding and the pointer-advance helper.
package mul_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int MUL_W_DEF  = 24;
  localparam int PROD_W_DEF = 2 * MUL_W_DEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

  // Successor index with wrap, used to move the round-robin pointer past a grant.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set bit of pending at or above rr_ptr,
// wrapping from N-1 back to 0.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (pending[idx]) begin
        grant     = PTR_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul24_arbiter.sv
// Shares one start/ready multi-cycle multiplier between N_REQ requesters,
// buffering one operand pair per requester and granting in round-robin order.
module mul24_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int MUL_W = MUL_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MUL_W-1:0] op_a,
  input  logic [N_REQ*MUL_W-1:0] op_b,
  output logic [N_REQ-1:0]       pending,
  output logic [N_REQ-1:0]       done,
  output logic [2*MUL_W-1:0]     res,
  output logic [N_REQ-1:0]       req_err,
  output logic                   mul_start,
  output logic [MUL_W-1:0]       mul_input0,
  output logic [MUL_W-1:0]       mul_input1,
  input  logic                   mul_ready,
  input  logic [2*MUL_W-1:0]     mul_output0
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_q;
  logic [PTR_W-1:0] pick;
  logic             any_valid;
  logic [N_REQ-1:0] accept;
  logic [MUL_W-1:0] slot_a [N_REQ];
  logic [MUL_W-1:0] slot_b [N_REQ];

  // A slot frees up in its done cycle, so a same-cycle re-request is accepted.
  always_comb accept = req & (~pending | done);

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  // Operand slots carry no reset; pending qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_a[i] <= op_a[i*MUL_W +: MUL_W];
        slot_b[i] <= op_b[i*MUL_W +: MUL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      pending    <= '0;
      done       <= '0;
      req_err    <= '0;
      res        <= '0;
      mul_start  <= 1'b0;
      mul_input0 <= '0;
      mul_input1 <= '0;
    end else begin
      pending <= (pending & ~done) | accept;
      req_err <= req_err | (req & pending & ~done);
      done    <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_q    <= pick;
            mul_input0 <= slot_a[pick];
            mul_input1 <= slot_b[pick];
            rr_ptr     <= PTR_W'(next_idx(int'(pick), N_REQ));
            mul_start  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mul_ready) begin
            res           <= mul_output0;
            done[grant_q] <= 1'b1;
            mul_start     <= 1'b0;
            state         <= COMPLETE;
          end
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul24_arbiter.md
Name: mul24_arbiter

Overview:
Shares one multi-cycle 24x24 multiplier (mul24_ins start/ready handshake) between N_REQ independent requesters, e.g. several full_reciprocal-style Newton-Raphson engines. Each request is buffered per requester, and the arbiter grants in round-robin order. It sequences the multiplier's start/ready handshake and returns the 48-bit product with a one-cycle done pulse to the owning requester. It sits between the requester FSMs and the single mul24 instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
MUL_W, 24, operand width; product is 2*MUL_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester 1-cycle request strobe; operands valid in same cycle
op_a  in  N_REQ*MUL_W  flattened operand A, slice i for requester i
op_b  in  N_REQ*MUL_W  flattened operand B
pending  out  N_REQ  request i buffered, not yet completed
done  out  N_REQ  one-hot 1-cycle pulse, product for requester i on res
res  out  2*MUL_W  product, valid only while done != 0
req_err  out  N_REQ  sticky: req[i] arrived while pending[i] (dropped); cleared by rst
mul_start  out  1  to multiplier start
mul_input0  out  MUL_W  to multiplier input0
mul_input1  out  MUL_W  to multiplier input1
mul_ready  in  1  from multiplier ready
mul_output0  in  2*MUL_W  from multiplier output0

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; pending=0, done=0, req_err=0, res=0, mul_start=0, mul_input0/1=0, rr_ptr=0. Reset mid-operation abandons the in-flight product; the multiplier shares rst.
- Capture: req[i]=1 and (pending[i]=0 or done[i]=1 same cycle) -> slot i := {op_a[i],op_b[i]}, pending[i]=1 next cycle. req[i] while pending[i]=1 and done[i]=0 -> dropped, req_err[i]=1.
- Round robin: search pending from rr_ptr upward, wrapping at N_REQ-1 -> 0. After a grant to g, rr_ptr := (g+1) mod N_REQ. No requester waits more than N_REQ-1 other grants.
- FSM states: IDLE, ISSUE, COMPLETE.
  - IDLE: mul_start=0. If pending != 0: grant g := RR winner, drive mul_input0/1 from slot g (registered), go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1; operands held stable. On mul_ready=1: res := mul_output0, done[g]=1 (registered, visible next cycle), go to COMPLETE.
  - COMPLETE: mul_start=0 (mandatory one-cycle gap), done[g] high this cycle only, pending[g] cleared at end of cycle. Go to IDLE.
- Latency: a req at cycle t with the arbiter idle -> pending at t+1, mul_start high from t+2. mul_ready at cycle r -> done/res at r+1, IDLE at r+2. Fixed overhead is 3 cycles plus multiplier latency.
- mul_ready while not in ISSUE is ignored.
- Outside the done cycle, res holds its last value and must not be consumed.
- Simultaneous events:
  - req on a slot not being granted is captured normally, even during ISSUE/COMPLETE.
  - req[g] in the COMPLETE cycle is accepted as a new request.
  - Several req in one cycle are all captured.

Decomposition:
- Package mul_arb_pkg holds N_REQ/MUL_W defaults, the state enum (IDLE, ISSUE, COMPLETE), and the product width localparam.
- Sub-module rr_picker is a combinational round-robin pick (pending, rr_ptr -> grant index, any_valid). It is reusable for other shared-resource arbiters.
- Operand slots, pointer and FSM stay in mul24_arbiter.

Test Plan:
- Single request: req[0] with op_a=0x000003, op_b=0x000005, multiplier latency 4 -> mul_start high t+2; done[0] with res=0x00000000000F; pending[0] low after.
- Fixed-point request: req[2] with op_a=0x0F0F0D, op_b=0x080000 -> done[2] with res=0x007878680000.
- Simultaneous requests: req=4'b1111 in one cycle, distinct operands -> done order 0,1,2,3, each with its own product; mul_start low ≥1 cycle between ops.
- Fairness: requester 0 re-requests in every COMPLETE cycle while 1 and 3 are pending -> grants 0,1,3,0, never 0,0.
- Overlapping request: req[1] while pending[1]=1 -> req_err[1]=1 (sticky); the first operands' product is returned unchanged.
- Reset mid-operation: rst during ISSUE -> next cycle mul_start=0, pending=0, done=0. A subsequent req[3] of 0x000002 x 0x000002 completes with res=0x4.
